// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and system reset release
// Optional loss-of-lock event counter: define PLL_RSTSEQ_LOL_COUNT_EN.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 10,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       status_locked,
  output logic       lock_fail,
  output logic [3:0] retry_count,
  output logic [7:0] lol_count
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic             sync_q, locked_s;
  logic             pll_rst_q, sys_reset_n_q, status_locked_q, lock_fail_q;

  // pll_locked comes from the PLL clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    retry_inc = retry_q + 4'd1;
    case (state_q)
      S_RESET_PLL: begin
        if (relock_req) begin
          cnt_d = '0;
        end else if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (relock_req) begin
          cnt_d   = '0;
          state_d = S_RESET_PLL;
        end else if (locked_s) begin
          cnt_d   = '0;
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = '0;
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABLE: begin
        if (relock_req) begin
          cnt_d   = '0;
          state_d = S_RESET_PLL;
        end else if (!locked_s) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d   = '0;
          retry_d = 4'd0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!locked_s || relock_req) begin
          state_d = S_RESET_PLL;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
        if (relock_req) begin
          retry_d = 4'd0;
          state_d = S_RESET_PLL;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_RESET_PLL;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_RESET_PLL;
      cnt_q           <= '0;
      retry_q         <= 4'd0;
      pll_rst_q       <= 1'b1;
      sys_reset_n_q   <= 1'b0;
      status_locked_q <= 1'b0;
      lock_fail_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      retry_q         <= retry_d;
      pll_rst_q       <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_reset_n_q   <= (state_d == S_RUN);
      status_locked_q <= (state_d == S_RUN);
      lock_fail_q     <= (state_d == S_FAIL);
    end
  end

`ifdef PLL_RSTSEQ_LOL_COUNT_EN
  logic [7:0] lol_q;
  logic       lol_inc;

  assign lol_inc = (state_q == S_RUN) && !locked_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lol_q <= 8'd0;
    end else if (lol_inc && (lol_q != 8'hFF)) begin
      lol_q <= lol_q + 8'd1;
    end
  end

  assign lol_count = lol_q;
`else
  assign lol_count = 8'd0;
`endif

  assign pll_rst       = pll_rst_q;
  assign sys_reset_n   = sys_reset_n_q;
  assign status_locked = status_locked_q;
  assign lock_fail     = lock_fail_q;
  assign retry_count   = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed and randomized bench with a phase/time-budget reference model
module tb_pll_reset_sequencer;

  localparam int RST = 4;
  localparam int LS  = 8;
  localparam int TO  = 32;
  localparam int MR  = 2;
`ifdef PLL_RSTSEQ_LOL_COUNT_EN
  localparam int LOL_ON = 1;
`else
  localparam int LOL_ON = 0;
`endif

  localparam int P_RST  = 10;
  localparam int P_WAIT = 20;
  localparam int P_STAB = 30;
  localparam int P_RUN  = 40;
  localparam int P_FAIL = 50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_reset_n, status_locked, lock_fail;
  logic [3:0] retry_count;
  logic [7:0] lol_count;

  always #10 clk = ~clk;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(RST), .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .status_locked(status_locked),
    .lock_fail(lock_fail), .retry_count(retry_count), .lol_count(lol_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rst_seen = 0;

  // Reference: current phase, cycles left in its budget, and a 2-deep lock history
  int m_phase, m_left, m_retry, m_lol;
  bit m_h0, m_h1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RST; m_left = RST; m_retry = 0; m_lol = 0; m_h0 = 0; m_h1 = 0;
  endtask

  task automatic model_step();
    bit ls;
    ls = m_h1; m_h1 = m_h0; m_h0 = pll_locked;
    case (m_phase)
      P_RST: begin
        if (relock_req) m_left = RST;
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = P_WAIT; m_left = TO; end
        end
      end
      P_WAIT: begin
        if (relock_req) begin m_phase = P_RST; m_left = RST; end
        else if (ls) begin m_phase = P_STAB; m_left = LS; end
        else begin
          m_left--;
          if (m_left == 0) begin
            m_retry++;
            if (m_retry == MR) m_phase = P_FAIL;
            else begin m_phase = P_RST; m_left = RST; end
          end
        end
      end
      P_STAB: begin
        if (relock_req) begin m_phase = P_RST; m_left = RST; end
        else if (!ls) begin m_phase = P_WAIT; m_left = TO; end
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = P_RUN; m_retry = 0; end
        end
      end
      P_RUN: begin
        if (!ls) begin
          if (m_lol < 255) m_lol++;
          m_phase = P_RST; m_left = RST;
        end else if (relock_req) begin m_phase = P_RST; m_left = RST; end
      end
      default: begin
        if (relock_req) begin m_retry = 0; m_phase = P_RST; m_left = RST; end
      end
    endcase
  endtask

  task automatic check_all();
    chk("pll_rst", pll_rst, (m_phase == P_RST || m_phase == P_FAIL));
    chk("sys_reset_n", sys_reset_n, (m_phase == P_RUN));
    chk("status_locked", status_locked, (m_phase == P_RUN));
    chk("lock_fail", lock_fail, (m_phase == P_FAIL));
    chk("retry_count", retry_count, m_retry);
    chk("lol_count", lol_count, m_lol * LOL_ON);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    cyc++;
    check_all();
    if (pll_rst === 1'b1) rst_seen = 1;
  endtask

  task automatic wait_run(input string tag, input int cap);
    int n = 0;
    while (sys_reset_n !== 1'b1 && n < cap) begin tick(); n++; end
    chk(tag, sys_reset_n, 1);
  endtask

  task automatic pulse_len(input string tag);
    int hi = 0;
    while (pll_rst === 1'b1 && hi < 100) begin hi++; tick(); end
    chk(tag, hi, RST);
  endtask

  initial begin
    int t0, n, hold;
    model_reset();
    repeat (3) tick();
    chk("reset_counter_zero", {retry_count, lol_count}, 0);

    // Nominal bring-up
    #5 reset_n = 1'b1;
    pulse_len("nominal_rst_pulse");
    repeat (10) tick();
    pll_locked = 1'b1;
    t0 = cyc;
    wait_run("nominal_run", 100);
    chk("nominal_lock_to_run", cyc - (t0 + 1), 2 + LS);
    chk("nominal_retry", retry_count, 0);

    // Lock bounce in STABLE
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    pll_locked = 1'b0;
    pulse_len("bounce_rst_pulse");
    rst_seen = 0;
    repeat (6) tick();
    pll_locked = 1'b1; repeat (5) tick();
    pll_locked = 1'b0; repeat (3) tick();
    pll_locked = 1'b1;
    t0 = cyc;
    wait_run("bounce_run", 100);
    chk("bounce_lock_to_run", cyc - (t0 + 1), 2 + LS);
    chk("bounce_no_repulse", rst_seen, 0);
    chk("bounce_retry", retry_count, 0);

    // Timeout and fail
    relock_req = 1'b1; pll_locked = 1'b0; tick(); relock_req = 1'b0;
    t0 = cyc;
    n = 0;
    while (lock_fail !== 1'b1 && n < 300) begin tick(); n++; end
    chk("fail_latency", cyc - t0, 2 * (RST + TO));
    chk("fail_retry", retry_count, MR);
    chk("fail_pll_rst", pll_rst, 1);
    repeat (5) tick();
    chk("fail_held", lock_fail, 1);
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    chk("fail_clear_flag", lock_fail, 0);
    chk("fail_clear_retry", retry_count, 0);
    pulse_len("fail_relock_pulse");
    repeat ($urandom_range(2, 20)) tick();
    pll_locked = 1'b1;
    wait_run("fail_recover_run", 100);

    // Loss of lock in RUN
    pll_locked = 1'b0;
    tick(); tick();
    chk("lol_still_run", sys_reset_n, 1);
    tick();
    chk("lol_sys_reset", sys_reset_n, 0);
    chk("lol_pll_rst", pll_rst, 1);
    chk("lol_count_1", lol_count, LOL_ON);
    pll_locked = 1'b1;
    wait_run("lol_recover_run", 100);
    chk("lol_count_kept", lol_count, LOL_ON);

    // Simultaneous relock request and loss of lock
    pll_locked = 1'b0;
    tick(); tick();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    chk("simul_lol_count", lol_count, 2 * LOL_ON);
    pulse_len("simul_single_pulse");
    pll_locked = 1'b1;
    wait_run("simul_recover_run", 100);

    // Asynchronous reset in the middle of STABLE
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    n = 0;
    while (m_phase != P_STAB && n < 50) begin tick(); n++; end
    chk("reach_stable", m_phase, P_STAB);
    repeat (5) tick();
    #5 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_pll_rst", pll_rst, 1);
    chk("async_sys_reset", sys_reset_n, 0);
    check_all();
    tick();
    #5 reset_n = 1'b1;
    wait_run("async_recover_run", 100);
    chk("async_lol_zero", lol_count, 0);
    chk("async_retry_zero", retry_count, 0);

    // Randomized soak against the model
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 70);
      end
      hold--;
      relock_req = ($urandom_range(0, 59) == 0);
      tick();
      relock_req = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
